mux_sweep_sequencer: RTL and testbench
======================================

Name: mux_sweep_sequencer

Overview:
- On-chip self-test sequencer for the 4:1 mux comparison block.
- Steps through all 64 combinations of {s1,s0,i3,i2,i1,i0} and drives them onto the mux inputs.
- After a programmable settle time, samples both mux outputs (BFG-generated and GF standard-cell), checks each against a golden 4:1 model, and accumulates error statistics.
- Sits in the user project wrapper between logic-analyzer control bits and the mux instance.

Parameters:
- SETTLE_CYCLES, 4, cycles held after applying a vector before sampling; legal range 2..255.
- CNT_W, 8, width of each saturating error counter; legal range 4..16.

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_ni  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  level; a rising edge seen in IDLE or DONE begins a sweep.
- abort_i  input  1  synchronous abort; returns to IDLE.
- vec_o  output  6  applied vector: [3:0]=i3..i0, [4]=s0, [5]=s1.
- bfg_in  input  1  BFG mux output (asynchronous to wb_clk_i).
- gf_in  input  1  GF mux output (asynchronous to wb_clk_i).
- busy_o  output  1  high while a sweep is in progress.
- done_o  output  1  sweep completed; held until the next start.
- bfg_err_cnt_o  output  CNT_W  BFG mismatches vs. golden model.
- gf_err_cnt_o  output  CNT_W  GF mismatches vs. golden model.
- disagree_cnt_o  output  CNT_W  cycles where bfg != gf.
- first_fail_vld_o  output  1  at least one mismatch has occurred.
- first_fail_vec_o  output  6  vector of the first mismatch (either implementation).

Behaviour:
- Reset values: every output 0; state IDLE; vector index 0.
- Input synchronisation: bfg_in and gf_in each pass through a 2-flop synchroniser before comparison.
- start_i edge detection: one register; pulse = start_i & ~start_q.
- FSM states:
  - IDLE: on start pulse, clear counters, first_fail_vld_o and done_o; set idx=0; go to APPLY.
  - APPLY (1 cycle): vec_o <= idx; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to SAMPLE. SETTLE_CYCLES >= 2 guarantees the synchroniser has flushed.
  - SAMPLE (1 cycle): compare and update counters. If idx==63 go to DONE, else idx++ and go to APPLY.
  - DONE: done_o=1, busy_o=0; vec_o holds 63; a start pulse restarts exactly as from IDLE.
- busy_o = 1 in APPLY, SETTLE and SAMPLE.
- Per-vector cost: SETTLE_CYCLES+2 cycles. Full sweep: 64*(SETTLE_CYCLES+2) cycles from the start pulse to the done_o rise (384 at default).
- Golden model: exp = vec_o[vec_o[5:4]], i.e. the data bit selected by {s1,s0}.
- Counter updates in SAMPLE:
  - bfg_err increments if bfg_sync != exp.
  - gf_err increments if gf_sync != exp.
  - disagree increments if bfg_sync != gf_sync.
  - All counters saturate at 2^CNT_W-1; no wrap.
- First fail: on the first SAMPLE with any golden mismatch, first_fail_vec_o <= vec_o and first_fail_vld_o <= 1. Later mismatches do not overwrite it.
- abort_i in any busy state goes to IDLE next cycle. Counters and first-fail registers are retained; done_o stays 0; vec_o resets to 0.
- abort_i has priority over a simultaneous start pulse.
- A start pulse while busy is ignored.
- Asynchronous reset mid-sweep: everything returns to reset values immediately. No sweep resumes until a new rising edge of start_i after reset release; a start_i already high at release does not count as an edge.

Decomposition:
- Package mux_sweep_pkg:
  - FSM state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE).
  - Constant NUM_VEC=64.
  - Constant VEC_W=6.
  - Function golden_mux(vec) returning the expected bit.
- Sub-module sync_2ff (1-bit, async active-low reset, reset value 0), instantiated twice.

Test Plan:
- Ideal mux model on both inputs, SETTLE_CYCLES=4, single start pulse -> done_o at cycle 384; all three counters 0; first_fail_vld_o=0; vec_o visits 0..63 in order.
- bfg_in stuck-at-0, gf ideal -> bfg_err=32, gf_err=0, disagree=32, first_fail_vec_o=6'b000001.
- gf_in = inverted golden, bfg ideal, CNT_W=4 -> gf_err saturates at 15, disagree=15, first_fail_vec_o=0.
- abort_i asserted during vector 10 with an injected error at vector 3 -> IDLE next cycle; busy_o=0; done_o=0; first_fail_vec_o=3 retained; vec_o=0.
- wb_rst_ni low during SETTLE of vector 20, start_i held high through release -> all outputs 0 immediately; no restart until start_i toggles low then high.
- Second start pulse while busy at vector 5 -> ignored; sweep completes normally at cycle 384.

Source files
------------

// File: rtl/mux_sweep_pkg.sv
// ---------------------------------------------------------------------------
// mux_sweep_pkg
// Shared definitions for the 4:1 mux self-test sequencer.
//   state_t      : sequencer FSM states
//   NUM_VEC      : number of stimulus vectors in one sweep
//   VEC_W        : width of one vector {s1,s0,i3,i2,i1,i0}
//   golden_mux() : reference 4:1 mux, returns the data bit picked by {s1,s0}
// ---------------------------------------------------------------------------
package mux_sweep_pkg;

    localparam int NUM_VEC = 64;
    localparam int VEC_W   = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // vec[3:0] are the data inputs i3..i0, vec[5:4] is the select {s1,s0}.
    function automatic logic golden_mux(input logic [VEC_W-1:0] vec);
        logic [3:0] data;
        data = vec[3:0];
        return data[vec[5:4]];
    endfunction

endpackage

// File: rtl/mux_sweep_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mux_sweep_sequencer.sv
// ---------------------------------------------------------------------------
// mux_sweep_sequencer
// Self-test sequencer for the 4:1 mux comparison block. Walks all 64
// {s1,s0,i3,i2,i1,i0} vectors, waits SETTLE_CYCLES after applying each one,
// samples the BFG and GF mux outputs through synchronisers, checks them
// against a golden 4:1 mux and keeps saturating error statistics.
//
// Ports:
//   wb_clk_i         : clock
//   wb_rst_ni        : asynchronous active-low reset
//   start_i          : level; a rising edge in IDLE or DONE starts a sweep
//   abort_i          : synchronous abort of a running sweep
//   vec_o            : applied vector, [3:0]=i3..i0, [4]=s0, [5]=s1
//   bfg_in, gf_in    : mux outputs under test (asynchronous)
//   busy_o           : sweep in progress
//   done_o           : sweep completed, held until the next start
//   bfg_err_cnt_o    : BFG mismatches against the golden mux
//   gf_err_cnt_o     : GF mismatches against the golden mux
//   disagree_cnt_o   : samples where BFG and GF differ
//   first_fail_vld_o : a golden mismatch has been seen this sweep
//   first_fail_vec_o : vector of the first golden mismatch
//   fsm_state        : current FSM state, for debug observation
//
// Control handshake: a start request is accepted only on a rising edge of
// start_i while busy_o is low; busy_o is high from acceptance until the last
// sample; done_o then rises and stays high until the next accepted start;
// abort_i is honoured only while busy_o is high and wins over any start.
// ---------------------------------------------------------------------------
module mux_sweep_sequencer
    import mux_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [VEC_W-1:0] vec_o,
    input  logic             bfg_in,
    input  logic             gf_in,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] bfg_err_cnt_o,
    output logic [CNT_W-1:0] gf_err_cnt_o,
    output logic [CNT_W-1:0] disagree_cnt_o,
    output logic             first_fail_vld_o,
    output logic [VEC_W-1:0] first_fail_vec_o,
    output state_t           fsm_state
);

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VEC - 1);

    state_t           state_q;
    state_t           state_d;
    logic             start_q;
    logic             start_pulse;
    logic [VEC_W-1:0] idx_q;
    logic [7:0]       settle_q;
    logic             bfg_sync;
    logic             gf_sync;
    logic             exp_bit;
    logic             bfg_bad;
    logic             gf_bad;
    logic             pair_bad;
    logic             abort_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    sync_2ff u_sync_bfg (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d     (bfg_in),
        .q     (bfg_sync)
    );

    sync_2ff u_sync_gf (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d     (gf_in),
        .q     (gf_sync)
    );

    // start_q resets high so a start_i already asserted when reset is
    // released is not mistaken for a rising edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start_i;
        end
    end

    assign start_pulse = start_i & ~start_q;
    assign busy_o      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == SAMPLE);
    assign done_o      = (state_q == DONE);
    assign abort_now   = busy_o & abort_i;
    assign fsm_state   = state_q;

    assign exp_bit  = golden_mux(vec_o);
    assign bfg_bad  = (bfg_sync != exp_bit);
    assign gf_bad   = (gf_sync != exp_bit);
    assign pair_bad = (bfg_sync != gf_sync);

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_pulse) state_d = APPLY;
            APPLY:   state_d = SETTLE;
            SETTLE:  if (settle_q == 8'd0) state_d = SAMPLE;
            SAMPLE:  state_d = (idx_q == LAST_IDX) ? DONE : APPLY;
            DONE:    if (start_pulse) state_d = APPLY;
            default: state_d = IDLE;
        endcase
        if (abort_now) begin
            state_d = IDLE;
        end
    end

    // Datapath: vector index, settle timer, statistics
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            vec_o            <= '0;
            idx_q            <= '0;
            settle_q         <= '0;
            bfg_err_cnt_o    <= '0;
            gf_err_cnt_o     <= '0;
            disagree_cnt_o   <= '0;
            first_fail_vld_o <= 1'b0;
            first_fail_vec_o <= '0;
        end else if (abort_now) begin
            // Statistics survive an abort; only the stimulus is parked.
            vec_o <= '0;
            idx_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_pulse) begin
                        idx_q            <= '0;
                        bfg_err_cnt_o    <= '0;
                        gf_err_cnt_o     <= '0;
                        disagree_cnt_o   <= '0;
                        first_fail_vld_o <= 1'b0;
                    end
                end
                APPLY: begin
                    vec_o    <= idx_q;
                    settle_q <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_q != 8'd0) begin
                        settle_q <= settle_q - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (bfg_bad)  bfg_err_cnt_o  <= sat_inc(bfg_err_cnt_o);
                    if (gf_bad)   gf_err_cnt_o   <= sat_inc(gf_err_cnt_o);
                    if (pair_bad) disagree_cnt_o <= sat_inc(disagree_cnt_o);
                    if ((bfg_bad || gf_bad) && !first_fail_vld_o) begin
                        first_fail_vld_o <= 1'b1;
                        first_fail_vec_o <= vec_o;
                    end
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sweep_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_sweep_sequencer
// Two sequencer instances (8-bit and 4-bit counters) share all control
// inputs. Each sees a mux model whose output is the ideal 4:1 result XOR a
// per-vector fault mask, so stuck-at, inverted and random faults are all
// expressed as masks and the expected statistics follow from counting.
// ---------------------------------------------------------------------------
module tb_mux_sweep_sequencer;
    import mux_sweep_pkg::*;

    localparam int SET     = 4;
    localparam int PER_VEC = SET + 2;
    localparam int SWEEP   = 64 * PER_VEC;
    localparam int BUDGET  = SWEEP + 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic [63:0] bfg_flip = '0;
    logic [63:0] gf_flip  = '0;

    logic [5:0] vec8, vec4, ffvec8, ffvec4;
    logic       busy8, busy4, done8, done4, ffv8, ffv4, bfg8, gf8, bfg4, gf4;
    logic [7:0] be8, ge8, dis8;
    logic [3:0] be4, ge4, dis4;
    state_t     st8, st4;

    int n_cmp  = 0;
    int n_fail = 0;

    // Ideal mux: data nibble is vec mod 16, select is vec div 16.
    function automatic logic gold(input logic [5:0] v);
        int d;
        int sel;
        d   = int'(v) % 16;
        sel = int'(v) / 16;
        return ((d >> sel) & 1) == 1;
    endfunction

    always_comb begin
        bfg8 = gold(vec8) ^ bfg_flip[vec8];
        gf8  = gold(vec8) ^ gf_flip[vec8];
        bfg4 = gold(vec4) ^ bfg_flip[vec4];
        gf4  = gold(vec4) ^ gf_flip[vec4];
    end

    mux_sweep_sequencer #(.SETTLE_CYCLES(SET), .CNT_W(8)) u_dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
        .vec_o(vec8), .bfg_in(bfg8), .gf_in(gf8), .busy_o(busy8), .done_o(done8),
        .bfg_err_cnt_o(be8), .gf_err_cnt_o(ge8), .disagree_cnt_o(dis8),
        .first_fail_vld_o(ffv8), .first_fail_vec_o(ffvec8), .fsm_state(st8)
    );

    mux_sweep_sequencer #(.SETTLE_CYCLES(SET), .CNT_W(4)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
        .vec_o(vec4), .bfg_in(bfg4), .gf_in(gf4), .busy_o(busy4), .done_o(done4),
        .bfg_err_cnt_o(be4), .gf_err_cnt_o(ge4), .disagree_cnt_o(dis4),
        .first_fail_vld_o(ffv4), .first_fail_vec_o(ffvec4), .fsm_state(st4)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural reference: count mismatches over the first n_vec vectors.
    task automatic model(input int w, input int n_vec, output int be, output int ge,
                         output int dis, output int ffv, output int ffvec);
        int sat;
        logic g, b, f;
        be = 0; ge = 0; dis = 0; ffv = 0; ffvec = 0;
        for (int v = 0; v < n_vec; v++) begin
            g = gold(6'(v));
            b = g ^ bfg_flip[v];
            f = g ^ gf_flip[v];
            if (b != g) be++;
            if (f != g) ge++;
            if (b != f) dis++;
            if ((b != g || f != g) && ffv == 0) begin
                ffv = 1;
                ffvec = v;
            end
        end
        sat = (1 << w) - 1;
        if (be > sat) be = sat;
        if (ge > sat) ge = sat;
        if (dis > sat) dis = sat;
    endtask

    function automatic logic [63:0] kind_mask(input int kind);
        logic [63:0] m;
        m = '0;
        for (int v = 0; v < 64; v++) begin
            case (kind)
                1: m[v] = gold(6'(v));   // forces output to 0
                2: m[v] = 1'b1;          // inverted output
                default: m[v] = 1'b0;
            endcase
        end
        return m;
    endfunction

    // ---------------- driver ----------------
    task automatic run_sweep(input string tag, input int restart_at);
        int cyc, vec_bad, busy_bad, ev;
        bit got_done;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1;
        cyc = 0; vec_bad = 0; busy_bad = 0; got_done = 0;
        while (!got_done && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) start_i = 1'b0;
            if (restart_at >= 0 && cyc == restart_at * PER_VEC + 1) start_i = 1'b1;
            if (restart_at >= 0 && cyc == restart_at * PER_VEC + 3) start_i = 1'b0;
            ev = (cyc % PER_VEC == 0) ? cyc / PER_VEC - 1 : cyc / PER_VEC;
            if (ev > 63) ev = 63;
            if (int'(vec8) != ev || int'(vec4) != ev) vec_bad++;
            if (busy8 != (cyc < SWEEP) || busy4 != (cyc < SWEEP)) busy_bad++;
            if (done8) got_done = 1;
        end
        check({tag, "_done_cycle"}, cyc, SWEEP);
        check({tag, "_done8"}, int'(done8), 1);
        check({tag, "_done4"}, int'(done4), 1);
        check({tag, "_vec_order_errs"}, vec_bad, 0);
        check({tag, "_busy_errs"}, busy_bad, 0);
    endtask

    task automatic check_stats(input string tag, input int e_be8, input int e_ge8,
                               input int e_dis8, input int e_be4, input int e_ge4,
                               input int e_dis4, input int e_ffv, input int e_ffvec);
        check({tag, "_bfg_err8"}, int'(be8), e_be8);
        check({tag, "_gf_err8"}, int'(ge8), e_ge8);
        check({tag, "_disagree8"}, int'(dis8), e_dis8);
        check({tag, "_bfg_err4"}, int'(be4), e_be4);
        check({tag, "_gf_err4"}, int'(ge4), e_ge4);
        check({tag, "_disagree4"}, int'(dis4), e_dis4);
        check({tag, "_ff_vld"}, int'(ffv8), e_ffv);
        check({tag, "_ff_vld4"}, int'(ffv4), e_ffv);
        if (e_ffv != 0) begin
            check({tag, "_ff_vec"}, int'(ffvec8), e_ffvec);
            check({tag, "_ff_vec4"}, int'(ffvec4), e_ffvec);
        end
    endtask

    task automatic wait_vec(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(negedge clk);
            if (int'(vec8) == n && busy8) ok = 1;
        end
        check($sformatf("wait_vec_%0d_reached", n), int'(ok), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"}, int'(vec8), 0);
        check({tag, "_busy"}, int'(busy8), 0);
        check({tag, "_done"}, int'(done8), 0);
        check({tag, "_bfg_err"}, int'(be8), 0);
        check({tag, "_gf_err"}, int'(ge8), 0);
        check({tag, "_disagree"}, int'(dis8), 0);
        check({tag, "_ff_vld"}, int'(ffv8), 0);
        check({tag, "_ff_vec"}, int'(ffvec8), 0);
        check({tag, "_state_idle"}, int'(st8), int'(IDLE));
        check({tag, "_state_idle4"}, int'(st4), int'(IDLE));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        int bfg_kind, gf_kind;
        int be8, ge8, dis8, be4, ge4, dis4, ffv, ffvec;
    } vec_rec_t;

    vec_rec_t tbl[4];

    initial begin
        int m_be, m_ge, m_dis, m_ffv, m_ffvec;
        int n_be, n_ge, n_dis, n_ffv, n_ffvec;
        bit ok;

        tbl[0] = '{"ideal",        0, 0,  0,  0,  0,  0,  0,  0, 0, 0};
        tbl[1] = '{"bfg_stuck0",   1, 0, 32,  0, 32, 15,  0, 15, 1, 1};
        tbl[2] = '{"gf_inverted",  0, 2,  0, 64, 64,  0, 15, 15, 1, 0};
        tbl[3] = '{"inv_vs_stuck", 2, 1, 64, 32, 32, 15, 15, 15, 1, 0};

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // table-driven sweeps
        for (int t = 0; t < 4; t++) begin
            bfg_flip = kind_mask(tbl[t].bfg_kind);
            gf_flip  = kind_mask(tbl[t].gf_kind);
            run_sweep(tbl[t].name, -1);
            check_stats(tbl[t].name, tbl[t].be8, tbl[t].ge8, tbl[t].dis8,
                        tbl[t].be4, tbl[t].ge4, tbl[t].dis4, tbl[t].ffv, tbl[t].ffvec);
        end

        // randomized fault masks against the counting model
        for (int r = 0; r < 5; r++) begin
            for (int v = 0; v < 64; v++) begin
                bfg_flip[v] = ($urandom_range(0, 3) == 0);
                gf_flip[v]  = ($urandom_range(0, 4) == 0);
            end
            run_sweep($sformatf("rand%0d", r), -1);
            model(8, 64, m_be, m_ge, m_dis, m_ffv, m_ffvec);
            model(4, 64, n_be, n_ge, n_dis, n_ffv, n_ffvec);
            check_stats($sformatf("rand%0d", r), m_be, m_ge, m_dis, n_be, n_ge, n_dis,
                        m_ffv, m_ffvec);
        end

        // start pulse while busy at vector 5 is ignored
        bfg_flip = '0; gf_flip = '0;
        run_sweep("restart_busy", 5);
        check_stats("restart_busy", 0, 0, 0, 0, 0, 0, 0, 0);

        // abort during vector 10, error injected at vector 3, start rises at once
        bfg_flip = '0; bfg_flip[3] = 1'b1; gf_flip = '0;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        wait_vec(10, ok);
        abort_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", int'(busy8), 0);
        check("abort_done", int'(done8), 0);
        check("abort_vec", int'(vec8), 0);
        check("abort_state", int'(st8), int'(IDLE));
        check("abort_ff_vld", int'(ffv8), 1);
        check("abort_ff_vec", int'(ffvec8), 3);
        model(8, 10, m_be, m_ge, m_dis, m_ffv, m_ffvec);
        check("abort_bfg_err", int'(be8), m_be);
        check("abort_disagree", int'(dis8), m_dis);
        @(negedge clk); abort_i = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_start_ignored", int'(busy8), 0);
        start_i = 1'b0;

        // async reset during SETTLE of vector 20, start_i high through release
        bfg_flip = '1; gf_flip = '0;
        run_sweep("pre_reset_clear", -1);
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        wait_vec(20, ok);
        @(negedge clk);
        check("pre_reset_errs", int'(be8), 20);
        start_i = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_no_restart_busy", int'(busy8), 0);
        check("post_reset_no_restart_state", int'(st8), int'(IDLE));
        bfg_flip = '0;
        run_sweep("after_reset", -1);
        check_stats("after_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
